divider: RTL and testbench

- Iterative radix-2 restoring integer divider. It is the companion of the Booth/Wallace multiplier in the CPU execute stage and serves DIV/DIVU.
- It accepts a dividend and divisor through a start/complete handshake and takes WIDTH+2 cycles per operation.
- The quotient is written to LO and the remainder to HI by the surrounding pipeline.
- Signed and unsigned modes are selected per operation.

---
 rtl/divider_if.sv | 32 +++
 rtl/divider.sv | 112 +++++++++++
 tb/tb_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// rtl/divider_if.sv - start/complete handshake bundle between the execute stage and the divider
//
// Purpose : groups the operand inputs and the result/status outputs of the divider.
// Signals : div        start request (sampled only while busy=0)
//           div_signed 1 = signed (DIV), 0 = unsigned (DIVU)
//           x, y       dividend and divisor
//           s, r       quotient and remainder
//           busy       operation in flight
//           complete   one-cycle pulse, s/r valid from this cycle
// Modports: master drives the request side, slave is the divider.
interface divider_if #(
    parameter int WIDTH = 32
) ();
    logic             div;
    logic             div_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             complete;

    modport master (
        output div, div_signed, x, y,
        input  s, r, busy, complete
    );

    modport slave (
        input  div, div_signed, x, y,
        output s, r, busy, complete
    );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring integer divider for DIV/DIVU
//
// Purpose : divides x by y in WIDTH+2 cycles from the accepting edge; signed
//           operations divide magnitudes and fix the signs afterwards.
// Ports   : div_clk  clock, all state changes on the rising edge
//           reset    synchronous, active-high
//           bus      divider_if.slave (div, div_signed, x, y -> s, r, busy, complete)
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      div_clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] dsr_q;
    logic             qsign_q;
    logic             rsign_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             complete_q;

    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH:0]   shift_rem;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    always_comb begin
        x_neg = bus.div_signed & bus.x[WIDTH-1];
        y_neg = bus.div_signed & bus.y[WIDTH-1];
        x_mag = x_neg ? -bus.x : bus.x;
        y_mag = y_neg ? -bus.y : bus.y;

        shift_rem = {rem_q, quo_q[WIDTH-1]};
        ge        = shift_rem >= {1'b0, dsr_q};
        // When the trial succeeds the true difference is below the divisor,
        // so the low WIDTH bits of the modular subtraction are exact.
        diff      = shift_rem[WIDTH-1:0] - dsr_q;
        rem_d     = ge ? diff : shift_rem[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            s_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    complete_q <= 1'b0;
                    if (bus.div) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= x_mag;
                        dsr_q   <= y_mag;
                        qsign_q <= x_neg ^ y_neg;
                        rsign_q <= x_neg;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    s_q        <= qsign_q ? -quo_q : quo_q;
                    r_q        <= rsign_q ? -rem_q : rem_q;
                    complete_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    complete_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.complete = complete_q;
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider
module tb_divider;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    divider_if #(.WIDTH(32)) bus ();

    divider #(.WIDTH(32)) dut (
        .div_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] s;
        logic [31:0] r;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division (truncating toward zero, remainder
    // takes the dividend sign); divide-by-zero follows the documented result.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] rm);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == 32'd0) begin
            q  = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            rm = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            rm = 32'(sa % sb);
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q  = 32'(ua / ub);
            rm = 32'(ua % ub);
        end
    endfunction

    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] so, output logic [31:0] ro, output int lat,
                         output logic busy1, output logic busy_after, output logic comp_after);
        bus.div        = 1'b1;
        bus.div_signed = sgn;
        bus.x          = a;
        bus.y          = b;
        step();
        bus.div = 1'b0;
        busy1   = bus.busy;
        lat     = 1;
        while (bus.complete !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        so = bus.s;
        ro = bus.r;
        step();
        busy_after = bus.busy;
        comp_after = bus.complete;
    endtask

    initial begin
        logic [31:0] so, ro, es, er;
        logic        b1, ba, ca;
        int          lat, n, pulses;
        logic        sgn;
        logic [31:0] a, b;

        n_cmp = 0;
        n_bad = 0;
        bus.div        = 1'b0;
        bus.div_signed = 1'b0;
        bus.x          = '0;
        bus.y          = '0;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          "u100_7"};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  "s_m7_2"};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          "u_fff9_2"};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          "s_ovf"};
        vecs[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          "s_7_m2"};
        vecs[5] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  "u_dz"};
        vecs[6] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          32'd1,          32'hFFFF_FFF0,  "s_dz_neg"};
        vecs[7] = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  "s_dz_pos"};
        vecs[8] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          "u9_3"};
        vecs[9] = '{1'b0, 32'd50,         32'd5,          32'd10,         32'd0,          "u50_5"};

        // reset state
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_complete", {31'd0, bus.complete}, 32'd0);
        chk("rst_s", bus.s, 32'd0);
        chk("rst_r", bus.r, 32'd0);

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sgn, vecs[i].x, vecs[i].y, so, ro, lat, b1, ba, ca);
            chk({vecs[i].name, "_s"}, so, vecs[i].s);
            chk({vecs[i].name, "_r"}, ro, vecs[i].r);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd34);
            chk({vecs[i].name, "_busy_start"}, {31'd0, b1}, 32'd1);
            chk({vecs[i].name, "_busy_end"}, {31'd0, ba}, 32'd0);
            chk({vecs[i].name, "_pulse_end"}, {31'd0, ca}, 32'd0);
        end

        // div pulsed with new operands mid-operation is ignored
        bus.div = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd100; bus.y = 32'd7;
        step();
        bus.div = 1'b0;
        n = 1;
        repeat (4) begin step(); n++; end
        bus.div = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
        step(); n++;
        bus.div = 1'b0;
        while (bus.complete !== 1'b1 && n < 100) begin step(); n++; end
        chk("ign_lat", 32'(n), 32'd34);
        chk("ign_s", bus.s, 32'd14);
        chk("ign_r", bus.r, 32'd2);
        repeat (3) step();
        chk("hold_s", bus.s, 32'd14);
        chk("hold_r", bus.r, 32'd2);

        // back-to-back: div held from the complete cycle, accepted once IDLE
        bus.div = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd100; bus.y = 32'd7;
        step();
        bus.div = 1'b0;
        n = 1;
        while (bus.complete !== 1'b1 && n < 100) begin step(); n++; end
        chk("b2b_first_lat", 32'(n), 32'd34);
        bus.div = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
        step(); n++;
        chk("b2b_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("b2b_idle_complete", {31'd0, bus.complete}, 32'd0);
        step(); n++;
        bus.div = 1'b0;
        chk("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_s_not_cleared", bus.s, 32'd14);
        while (bus.complete !== 1'b1 && n < 200) begin step(); n++; end
        chk("b2b_second_lat", 32'(n), 32'd69);
        chk("b2b_s", bus.s, 32'd3);
        chk("b2b_r", bus.r, 32'd0);
        step();

        // reset mid-operation
        bus.div = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd100; bus.y = 32'd7;
        step();
        bus.div = 1'b0;
        n = 1;
        while (n < 10) begin step(); n++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_complete", {31'd0, bus.complete}, 32'd0);
        chk("mid_rst_s", bus.s, 32'd0);
        chk("mid_rst_r", bus.r, 32'd0);
        pulses = 0;
        repeat (40) begin
            step();
            if (bus.complete === 1'b1) pulses++;
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
        do_op(1'b0, 32'd50, 32'd5, so, ro, lat, b1, ba, ca);
        chk("after_rst_s", so, 32'd10);
        chk("after_rst_r", ro, 32'd0);
        chk("after_rst_lat", 32'(lat), 32'd34);

        // randomized sweep against the reference
        for (int k = 0; k < 1200; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == 32'd0) b = 32'd1;
            if (k % 50 == 0) a = 32'h8000_0000;
            ref_div(sgn, a, b, es, er);
            do_op(sgn, a, b, so, ro, lat, b1, ba, ca);
            chk($sformatf("rnd%0d_s(%0d %h/%h)", k, sgn, a, b), so, es);
            chk($sformatf("rnd%0d_r(%0d %h/%h)", k, sgn, a, b), ro, er);
            chk($sformatf("rnd%0d_ident", k), so * b + ro, a);
            if (k % 100 == 0) chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'd34);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
